// File: rtl/bootrom_copier_if.sv
// Bus bundle for the boot copy engine: the boot ROM read port and the
// RAM write port. The copier is the master on both sides.
interface bootrom_copier_if;
   logic        rom_req;
   logic [31:0] rom_addr;
   logic [31:0] rom_rdata;
   logic        rom_rvalid;
   logic        rom_fault;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_ready;

   modport master (
      output rom_req, rom_addr,
      input  rom_rdata, rom_rvalid, rom_fault,
      output ram_we, ram_addr, ram_wdata,
      input  ram_ready
   );

   modport slave (
      input  rom_req, rom_addr,
      output rom_rdata, rom_rvalid, rom_fault,
      input  ram_we, ram_addr, ram_wdata,
      output ram_ready
   );
endinterface

// File: rtl/bootrom_copier.sv
// Boot-time copy engine: reads words from the boot ROM and writes them to RAM.
// The ROM cannot be stalled, so reads are only issued while there is room
// for their data in the skid FIFO (inflight + fifo_count < FIFO_DEPTH).
module bootrom_copier #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      err_addr,
   bootrom_copier_if.master bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_next;
   logic [31:0]      src_q, dst_q;
   logic [LEN_W-1:0] len_q, issued, written, target;
   logic [CNT_W-1:0] inflight, fifo_count;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic             faulted, error_q, zero_done;
   logic             accept_start, credit_ok, rom_accept, rom_reject;
   logic             push, pop, complete;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A start during the zero-length done cycle counts as "while busy".
   assign accept_start = (state == IDLE) && start && !zero_done;
   assign credit_ok    = (issued < len_q) &&
                         ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
   assign rom_accept   = bus.rom_req && !bus.rom_fault;
   assign rom_reject   = bus.rom_req && bus.rom_fault;
   // Late read data arriving after an abort is dropped in IDLE.
   assign push         = bus.rom_rvalid && (state != IDLE);
   assign pop          = bus.ram_we && bus.ram_ready;
   assign complete     = (state == DRAIN) && (inflight == '0) &&
                         (fifo_count == '0) && (written == target);

   assign bus.rom_addr  = src_q + 32'({issued, 2'b00});
   assign bus.ram_we    = (fifo_count != '0);
   assign bus.ram_wdata = fifo_mem[rd_ptr];
   assign bus.ram_addr  = dst_q + 32'({written, 2'b00});

   assign busy  = (state != IDLE) || zero_done;
   assign done  = complete || zero_done;
   assign error = error_q || (complete && faulted);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic and ROM request generation.
   always_comb begin
      state_next  = state;
      bus.rom_req = 1'b0;
      case (state)
         IDLE: begin
            if (accept_start && (len_words != '0)) state_next = RUN;
         end
         RUN: begin
            bus.rom_req = credit_ok;
            if (credit_ok && bus.rom_fault) state_next = DRAIN;
            else if (issued == len_q)       state_next = DRAIN;
         end
         DRAIN: begin
            if (complete) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Copy parameters, progress counters and fault/error bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         issued    <= '0;
         written   <= '0;
         target    <= '0;
         faulted   <= 1'b0;
         error_q   <= 1'b0;
         zero_done <= 1'b0;
         err_addr  <= '0;
      end else begin
         zero_done <= accept_start && (len_words == '0);
         if (accept_start) begin
            src_q   <= src_addr & 32'hFFFF_FFFC;
            dst_q   <= dst_addr & 32'hFFFF_FFFC;
            len_q   <= len_words;
            issued  <= '0;
            written <= '0;
            target  <= '0;
            faulted <= 1'b0;
            error_q <= 1'b0;
         end
         if (rom_accept) issued <= issued + LEN_W'(1);
         if (rom_reject) begin
            err_addr <= bus.rom_addr;
            faulted  <= 1'b1;
            target   <= issued;
         end else if ((state == RUN) && (issued == len_q)) begin
            target <= len_q;
         end
         if (pop) written <= written + LEN_W'(1);
         if (complete && faulted) error_q <= 1'b1;
      end
   end

   // Skid FIFO and outstanding-read tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         inflight   <= inflight + CNT_W'(rom_accept) - CNT_W'(push);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         if (push) begin
            fifo_mem[wr_ptr] <= bus.rom_rdata;
            wr_ptr           <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
      end
   end
endmodule
